// File: rtl/icache_sa_axi4.sv
// ---------------------------------------------------------------------------
// icache_sa_axi4 : set-associative, read-only instruction cache. Misses are
// refilled with a single AXI4 INCR burst of one full line.
//
// Ports
//   aclk, areset        : clock, asynchronous active-high reset
//   cpu_req             : fetch request (looked up combinationally in IDLE)
//   cpu_req_addr        : byte address, bits [1:0] ignored
//   cpu_req_data        : instruction word for a hit
//   cpu_rvalid          : cpu_req_data valid (hit this cycle)
//   busy                : CPU must hold its request (miss, refill or flush)
//   flush               : invalidate every line at the next clock edge
//   bus_err             : sticky, set by any non-OKAY refill beat
//   M_AXI_AR* / M_AXI_R*: AXI4 read-address and read-data channels
//
// Address layout: | tag | index (log2 SETS) | offset (log2 LINE_WORDS) | 2'b00 |
// ---------------------------------------------------------------------------
module icache_sa_axi4 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  output logic [DATA_WIDTH-1:0] cpu_req_data,
  output logic                  cpu_rvalid,
  output logic                  busy,
  input  logic                  flush,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARLOCK,
  output logic [3:0]            M_AXI_ARCACHE,
  output logic [2:0]            M_AXI_ARPROT,
  output logic [3:0]            M_AXI_ARQOS,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_e;

  state_e                  state_q, state_d;
  logic [SETS-1:0]         valid_q [WAYS];
  logic [SETS-1:0]         valid_d [WAYS];
  logic [WAY_W-1:0]        rr_q [SETS];
  logic [WAY_W-1:0]        rr_d [SETS];
  logic [OFF_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
  logic [WAY_W-1:0]        victim_q, victim_d;
  logic                    err_seen_q, err_seen_d;
  logic                    flush_seen_q, flush_seen_d;
  logic                    bus_err_q, bus_err_d;

  // Tag and data storage carry no reset; the valid bits gate every use.
  logic [TAG_W-1:0]        tag_mem  [WAYS][SETS];
  logic [DATA_WIDTH-1:0]   data_mem [WAYS][SETS][LINE_WORDS];

  logic [OFF_W-1:0]        req_off;
  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic [WAY_W-1:0]        hit_way;
  logic                    inv_found;
  logic [WAY_W-1:0]        inv_way;
  logic [WAY_W-1:0]        victim_sel;
  logic                    in_idle;
  logic                    data_we;
  logic                    tag_we;
  logic                    unused_addr_bits;

  assign req_off  = cpu_req_addr[2 +: OFF_W];
  assign req_idx  = cpu_req_addr[2+OFF_W +: IDX_W];
  assign req_tag  = cpu_req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign fill_idx = line_addr_q[2+OFF_W +: IDX_W];
  assign fill_tag = line_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign in_idle  = (state_q == S_IDLE);
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  // Combinational lookup of the indexed set plus victim choice for a miss.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    if (WAYS == 1)      victim_sel = '0;
    else if (inv_found) victim_sel = inv_way;
    else                victim_sel = rr_q[req_idx];
  end

  assign cpu_req_data = data_mem[hit_way][req_idx][req_off];
  // A flush in IDLE stalls the CPU for that cycle regardless of hit or miss.
  assign cpu_rvalid   = !areset && in_idle && cpu_req && !flush && hit;
  assign busy         = !areset && (!in_idle || flush || (cpu_req && !hit));
  assign bus_err      = bus_err_q;

  assign M_AXI_ARADDR  = line_addr_q;
  assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARVALID = (state_q == S_AR);
  assign M_AXI_RREADY  = (state_q == S_R);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    rr_d         = rr_q;
    beat_cnt_d   = beat_cnt_q;
    line_addr_d  = line_addr_q;
    victim_d     = victim_q;
    err_seen_d   = err_seen_q;
    flush_seen_d = flush_seen_q;
    bus_err_d    = bus_err_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && cpu_req && !hit) begin
          line_addr_d  = {cpu_req_addr[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
          victim_d     = victim_sel;
          // Victim is invalidated up front so partially refilled data can never hit.
          valid_d[victim_sel][req_idx] = 1'b0;
          beat_cnt_d   = '0;
          err_seen_d   = 1'b0;
          flush_seen_d = 1'b0;
          state_d      = S_AR;
        end
      end
      S_AR: begin
        if (M_AXI_ARREADY) state_d = S_R;
      end
      S_R: begin
        if (M_AXI_RVALID) begin
          data_we    = 1'b1;
          beat_cnt_d = beat_cnt_q + OFF_W'(1);
          if (M_AXI_RRESP != 2'b00) begin
            err_seen_d = 1'b1;
            bus_err_d  = 1'b1;
          end
          if (M_AXI_RLAST) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            if (!err_seen_q && (M_AXI_RRESP == 2'b00) && !flush_seen_q && !flush) begin
              valid_d[victim_q][fill_idx] = 1'b1;
              tag_we                      = 1'b1;
              rr_d[fill_idx]              = rr_q[fill_idx] + WAY_W'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
      if (!in_idle) flush_seen_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      beat_cnt_q   <= '0;
      line_addr_q  <= '0;
      victim_q     <= '0;
      err_seen_q   <= 1'b0;
      flush_seen_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      beat_cnt_q   <= beat_cnt_d;
      line_addr_q  <= line_addr_d;
      victim_q     <= victim_d;
      err_seen_q   <= err_seen_d;
      flush_seen_q <= flush_seen_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (data_we) data_mem[victim_q][fill_idx][beat_cnt_q] <= M_AXI_RDATA;
    if (tag_we)  tag_mem[victim_q][fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_icache_sa_axi4.sv
// ---------------------------------------------------------------------------
// tb_icache_sa_axi4 : directed bench for icache_sa_axi4 with default
// parameters (2 ways, 64 sets, 8-word lines). The bench plays the AXI slave;
// every refill word is dat(address) so hit data is predictable.
// ---------------------------------------------------------------------------
module tb_icache_sa_axi4;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cpu_req;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_data;
  logic        cpu_rvalid;
  logic        busy;
  logic        flush;
  logic        bus_err;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  icache_sa_axi4 dut (
    .aclk(aclk), .areset(areset),
    .cpu_req(cpu_req), .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_rvalid(cpu_rvalid), .busy(busy), .flush(flush), .bus_err(bus_err),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Takes the miss edge, then serves one burst for line 'base'.
  // ar_wait: cycles ARREADY is held low; gap: idle cycles before each beat;
  // err_beat / flush_beat: beat index carrying SLVERR / a flush pulse (-1 = none).
  task automatic serve(input logic [31:0] base, input int ar_wait, input int gap,
                       input int err_beat, input int flush_beat);
    int n;
    tick();
    n = 0;
    while (!arvalid && n < 20) begin tick(); n++; end
    chk("arvalid_rise", arvalid, 1'b1);
    chk("araddr", araddr, base);
    chk("arlen", arlen, 32'd7);
    chk("arsize_burst_cache", {arsize, arburst, arcache, arlock, arprot, arqos},
        {3'b010, 2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000});
    for (int i = 0; i < ar_wait; i++) begin
      chk("araddr_stable", araddr, base);
      chk("arvalid_held", arvalid, 1'b1);
      chk("busy_ar", busy, 1'b1);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        #1;
        chk("busy_gap", busy, 1'b1);
        chk("rvalid_gap", cpu_rvalid, 1'b0);
        tick();
      end
      rvalid = 1'b1;
      rdata  = dat(base + 32'(4 * b));
      rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      rlast  = (b == 7);
      flush  = (b == flush_beat);
      #1;
      chk("rready_beat", rready, 1'b1);
      chk("no_ar_in_r", arvalid, 1'b0);
      tick();
      flush = 1'b0;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  initial begin
    areset = 1'b1; cpu_req = 1'b0; cpu_req_addr = '0; flush = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    areset = 1'b0;
    tick();

    // Cold miss on 0x100, then hit on word 0 and word 7
    cpu_req = 1'b1; cpu_req_addr = 32'h100;
    #1;
    chk("cold_miss_busy", busy, 1'b1);
    chk("cold_miss_rvalid", cpu_rvalid, 1'b0);
    serve(32'h100, 0, 0, -1, -1);
    chk("cold_hit_rvalid", cpu_rvalid, 1'b1);
    chk("cold_hit_busy", busy, 1'b0);
    chk("cold_hit_data", cpu_req_data, dat(32'h100));
    cpu_req_addr = 32'h11C;
    #1;
    chk("w7_hit_rvalid", cpu_rvalid, 1'b1);
    chk("w7_hit_data", cpu_req_data, dat(32'h11C));
    tick();
    chk("w7_no_ar", arvalid, 1'b0);

    // Conflict: three lines into set 0
    cpu_req_addr = 32'h0000;
    serve(32'h0000, 0, 0, -1, -1);
    chk("fill0_hit", cpu_rvalid, 1'b1);
    chk("fill0_data", cpu_req_data, dat(32'h0000));
    cpu_req_addr = 32'h4000;
    #1;
    chk("fill4k_miss", busy, 1'b1);
    serve(32'h4000, 0, 0, -1, -1);
    chk("fill4k_data", cpu_req_data, dat(32'h4000));
    cpu_req_addr = 32'h8000;
    #1;
    serve(32'h8000, 0, 0, -1, -1);
    chk("fill8k_hit", cpu_rvalid, 1'b1);
    chk("fill8k_data", cpu_req_data, dat(32'h8000));
    cpu_req_addr = 32'h0000;
    #1;
    chk("evicted_0_miss", busy, 1'b1);
    chk("evicted_0_rvalid", cpu_rvalid, 1'b0);
    cpu_req_addr = 32'h4004;
    #1;
    chk("kept_4k_hit", cpu_rvalid, 1'b1);
    chk("kept_4k_data", cpu_req_data, dat(32'h4004));
    cpu_req = 1'b0;
    tick();

    // Backpressure with address wiggling during the refill
    cpu_req = 1'b1; cpu_req_addr = 32'h200;
    #1;
    chk("bp_miss", busy, 1'b1);
    @(posedge aclk);
    #1;
    cpu_req_addr = 32'h3000;
    chk("bp_arvalid", arvalid, 1'b1);
    // serve() first consumes one edge; the bench is already in AR so it just waits.
    serve(32'h200, 3, 1, -1, -1);
    cpu_req_addr = 32'h200;
    #1;
    chk("bp_hit", cpu_rvalid, 1'b1);
    chk("bp_data", cpu_req_data, dat(32'h200));
    cpu_req_addr = 32'h218;
    #1;
    chk("bp_data_w6", cpu_req_data, dat(32'h218));

    // Flush in IDLE overrides a hit, then the line misses
    flush = 1'b1;
    #1;
    chk("flush_idle_rvalid", cpu_rvalid, 1'b0);
    chk("flush_idle_busy", busy, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    chk("after_flush_miss", busy, 1'b1);
    cpu_req = 1'b0;
    tick();

    // Flush during R: burst completes, line stays invalid
    cpu_req = 1'b1; cpu_req_addr = 32'h400;
    #1;
    serve(32'h400, 0, 0, -1, 2);
    chk("flushR_remiss_busy", busy, 1'b1);
    chk("flushR_remiss_rvalid", cpu_rvalid, 1'b0);
    cpu_req = 1'b0;
    tick();
    chk("flushR_idle", arvalid, 1'b0);

    // SLVERR on beat 3, then clean retry of the same line
    cpu_req = 1'b1; cpu_req_addr = 32'h600;
    #1;
    serve(32'h600, 0, 0, 3, -1);
    chk("err_bus_err", bus_err, 1'b1);
    chk("err_remiss", busy, 1'b1);
    chk("err_rvalid", cpu_rvalid, 1'b0);
    serve(32'h600, 0, 0, -1, -1);
    chk("retry_hit", cpu_rvalid, 1'b1);
    chk("retry_data", cpu_req_data, dat(32'h600));
    chk("err_sticky", bus_err, 1'b1);
    cpu_req = 1'b0;
    tick();

    // Reset asserted while AR is pending
    cpu_req = 1'b1; cpu_req_addr = 32'h800;
    tick();
    chk("pre_rst_arvalid", arvalid, 1'b1);
    areset = 1'b1;
    #1;
    chk("rst_ar_arvalid", arvalid, 1'b0);
    chk("rst_ar_rready", rready, 1'b0);
    chk("rst_ar_busy", busy, 1'b0);
    chk("rst_ar_rvalid", cpu_rvalid, 1'b0);
    chk("rst_ar_bus_err", bus_err, 1'b0);
    cpu_req = 1'b0;
    tick();
    areset = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_req_addr = 32'h600;
    #1;
    chk("post_rst_miss", busy, 1'b1);
    chk("post_rst_rvalid", cpu_rvalid, 1'b0);
    cpu_req = 1'b0;

    // Stray RVALID in IDLE is not accepted
    rvalid = 1'b1;
    #1;
    chk("idle_rready", rready, 1'b0);
    tick();
    rvalid = 1'b0;
    chk("idle_stays", arvalid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
